// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back unit.
//
// Drives the register-file write port. It captures the MEM-stage result every
// cycle, extracts sub-word load data, redirects jal/jalr link writes to $31 and
// counts retired instructions. The write data is fully formed before the
// register, so every output comes straight from a flop.
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           synchronous reset, active-high
//   stall         hold all WB registers this cycle
//   flush         insert a bubble into WB this cycle (wins over stall)
//   m_valid       MEM stage holds a real instruction
//   m_regwrite    instruction writes a GPR
//   m_memtoreg    1 = load data, 0 = ALU result
//   m_link        jal/jalr link write (forces dest to $31, data to pc+8)
//   m_ld_size     00 byte, 01 half, 10/11 word
//   m_ld_signed   sign-extend sub-word loads
//   m_byte_off    effective address bits [1:0]
//   m_dest        destination register from decode
//   m_alu_result  ALU output
//   m_mem_rdata   aligned word read from data memory
//   m_pc_plus8    link value
//   RegWrite      register-file write enable
//   W_addr        register-file write address
//   W_data        register-file write data
//   wb_valid      WB holds a real instruction
//   retire_count  instructions retired since reset (wraps silently)

module wb_stage #(
  parameter int width      = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  m_valid,
  input  logic                  m_regwrite,
  input  logic                  m_memtoreg,
  input  logic                  m_link,
  input  logic [1:0]            m_ld_size,
  input  logic                  m_ld_signed,
  input  logic [1:0]            m_byte_off,
  input  logic [addr_width-1:0] m_dest,
  input  logic [width-1:0]      m_alu_result,
  input  logic [width-1:0]      m_mem_rdata,
  input  logic [width-1:0]      m_pc_plus8,
  output logic                  RegWrite,
  output logic [addr_width-1:0] W_addr,
  output logic [width-1:0]      W_data,
  output logic                  wb_valid,
  output logic [31:0]           retire_count
);

  localparam logic [addr_width-1:0] LINK_REG = {addr_width{1'b1}};

  logic                  regwrite_q, regwrite_d;
  logic [addr_width-1:0] w_addr_q, w_addr_d;
  logic [width-1:0]      w_data_q, w_data_d;
  logic                  wb_valid_q;
  logic [31:0]           retire_cnt_q;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [width-1:0]      ld_val;

  // Little-endian lane select; the half lane ignores byte_off[0] (no trap).
  always_comb begin
    ld_byte = m_mem_rdata[{m_byte_off, 3'b000} +: 8];
    ld_half = m_mem_rdata[{m_byte_off[1], 4'b0000} +: 16];
    case (m_ld_size)
      2'b00:   ld_val = {{(width-8){m_ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{(width-16){m_ld_signed & ld_half[15]}}, ld_half};
      default: ld_val = m_mem_rdata;
    endcase
  end

  always_comb begin
    w_addr_d = m_link ? LINK_REG : m_dest;
    // $0 writes are dropped here as well as in the register file so the
    // write port never shows a spurious enable.
    regwrite_d = m_valid & (m_regwrite | m_link) & (w_addr_d != '0);
    if (m_link)
      w_data_d = m_pc_plus8;
    else if (m_memtoreg)
      w_data_d = ld_val;
    else
      w_data_d = m_alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      wb_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else if (flush) begin
      regwrite_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      wb_valid_q <= 1'b0;
    end else if (!stall) begin
      // A held write under stall simply rewrites the same value; harmless.
      regwrite_q <= regwrite_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      wb_valid_q <= m_valid;
      if (m_valid)
        retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign RegWrite     = regwrite_q;
  assign W_addr       = w_addr_q;
  assign W_data       = w_data_q;
  assign wb_valid     = wb_valid_q;
  assign retire_count = retire_cnt_q;

endmodule
